// File: rtl/tdm_demux2.sv
// Two-channel bit-interleaved TDM demultiplexer with HUNT/LOCK frame alignment.
// Channel 0 is carried on even slots and channel 1 on odd slots, MSB first.
//
// state | meaning
// HUNT  | not aligned; discard slots until a valid slot arrives with sync
// LOCK  | aligned; assemble words, freewheel across frame boundaries
module tdm_demux2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic             out_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam int SW = $clog2(2 * WIDTH);
  localparam logic [SW-1:0] LAST = SW'(2 * WIDTH - 1);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t           state;
  logic [SW-1:0]    slot;
  logic [WIDTH-1:0] sr0;
  logic [WIDTH-1:0] sr1;

  always_ff @(posedge clk) begin
    out_valid <= 1'b0;
    sync_err  <= 1'b0;
    if (rst) begin
      state  <= HUNT;
      locked <= 1'b0;
      slot   <= '0;
      sr0    <= '0;
      sr1    <= '0;
      q0     <= '0;
      q1     <= '0;
    end else if (din_valid) begin
      case (state)
        HUNT: begin
          if (sync) begin
            state  <= LOCK;
            locked <= 1'b1;
            sr0    <= {{(WIDTH-1){1'b0}}, din};
            sr1    <= '0;
            slot   <= SW'(1);
          end
        end
        LOCK: begin
          // Misplaced sync restarts the frame on this bit; it also wins over completion.
          if (sync && slot != '0) begin
            sync_err <= 1'b1;
            sr0      <= {{(WIDTH-1){1'b0}}, din};
            sr1      <= '0;
            slot     <= SW'(1);
          end else begin
            if (slot[0])
              sr1 <= {sr1[WIDTH-2:0], din};
            else
              sr0 <= {sr0[WIDTH-2:0], din};
            if (slot == LAST) begin
              q0        <= sr0;
              q1        <= {sr1[WIDTH-2:0], din};
              out_valid <= 1'b1;
              slot      <= '0;
            end else begin
              slot <= slot + SW'(1);
            end
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
